// File: rtl/rv_div_unit.sv
// rv_div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU, restoring shift-subtract,
// one quotient bit per cycle. Fixed latency of N+2 cycles per operation.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// the iteration phase and complete in 2 cycles.
module rv_div_unit #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;      // dividend magnitude, becomes the quotient
  logic [N-1:0]  rem;      // partial remainder
  logic [N-1:0]  dsr;      // divisor magnitude
  logic [N-1:0]  a_raw;    // original dividend, remainder for divide-by-zero
  logic          op_rem;
  logic          neg_q;
  logic          neg_r;
  logic          b_zero;
  logic          ovf;

  logic          load;
  logic          step;
  logic          busy_d;
  logic          done_d;
  logic [N-1:0]  result_d;

  // Operand classification at capture time
  logic          is_signed;
  logic          bzero_in;
  logic          ovf_in;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;

  assign is_signed = ~op[0];
  assign bzero_in  = (B == '0);
  assign ovf_in    = is_signed & (A == {1'b1, {(N-1){1'b0}}}) & (&B);
  assign a_mag     = (is_signed && A[N-1]) ? -A : A;
  assign b_mag     = (is_signed && B[N-1]) ? -B : B;

  // One restoring step; the extra top bit is the borrow of the trial subtract
  logic [N+1:0]  shifted;
  logic [N+1:0]  diff;
  logic          qbit;
  logic [N-1:0]  rem_nxt;

  assign shifted = {1'b0, rem, dvd[N-1]};
  assign diff    = shifted - {2'b00, dsr};
  assign qbit    = ~diff[N+1];
  assign rem_nxt = qbit ? diff[N-1:0] : shifted[N-1:0];

  // Sign correction and RISC-V special cases applied over the iterated value
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;
  logic [N-1:0]  fix_val;

  always_comb begin
    q_fix = neg_q ? -dvd : dvd;
    r_fix = neg_r ? -rem : rem;
    if (b_zero) begin
      q_fix = '1;
      r_fix = a_raw;
    end else if (ovf) begin
      q_fix = {1'b1, {(N-1){1'b0}}};
      r_fix = '0;
    end
    fix_val = op_rem ? r_fix : q_fix;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    result_d  = result;
    case (state)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          busy_d = 1'b1;
`ifdef DIV_EARLY_OUT_EN
          state_nxt = (bzero_in || ovf_in) ? FIX : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC: begin
        step   = 1'b1;
        busy_d = 1'b1;
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        done_d    = 1'b1;
        result_d  = fix_val;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dvd    <= '0;
      rem    <= '0;
      dsr    <= '0;
      a_raw  <= '0;
      op_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      busy   <= busy_d;
      done   <= done_d;
      result <= result_d;
      if (load) begin
        cnt    <= CW'(N - 1);
        dvd    <= a_mag;
        rem    <= '0;
        dsr    <= b_mag;
        a_raw  <= A;
        op_rem <= op[1];
        neg_q  <= is_signed & (A[N-1] ^ B[N-1]);
        neg_r  <= is_signed & A[N-1];
        b_zero <= bzero_in;
        ovf    <= ovf_in;
      end else if (step) begin
        cnt <= cnt - CW'(1);
        dvd <= {dvd[N-2:0], qbit};
        rem <= rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: directed RV32M cases, randomized
// operations against an arithmetic reference model, abort and back-to-back.
module tb_rv_div_unit;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int           vecs = 0;
  int           errs = 0;
  logic [N-1:0] exp_result;

  always #5 clk = ~clk;

  rv_div_unit #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (a),
    .B      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // RISC-V division semantics from plain arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    int sx;
    int sy;
    if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : 32'h8000_0000;
    if (o[0]) return o[1] ? (x % y) : (x / y);
    sx = x;
    sy = y;
    return o[1] ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
`ifdef DIV_EARLY_OUT_EN
    if (y == 32'h0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 2;
`endif
    return N + 2;
  endfunction

  // Called at posedge+1; issues start in this cycle and follows it to done.
  // Ends in the done cycle, so a following call starts back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv, input string name);
    int   lat;
    logic eb;
    logic ed;
    lat   = ref_latency(o, x, y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start = 1'b0;
      eb = (cyc < lat);
      ed = (cyc == lat);
      vecs++;
      if (busy !== eb) begin
        errs++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", name, cyc, busy, eb);
      end
      vecs++;
      if (done !== ed) begin
        errs++;
        $display("FAIL %s done cyc=%0d got=%b want=%b", name, cyc, done, ed);
      end
      vecs++;
      if (cyc < lat) begin
        if (result !== exp_result) begin
          errs++;
          $display("FAIL %s held result cyc=%0d got=%h want=%h", name, cyc, result, exp_result);
        end
      end else begin
        if (result !== expv) begin
          errs++;
          $display("FAIL %s result op=%0d a=%h b=%h got=%h want=%h", name, o, x, y, result, expv);
        end
        exp_result = expv;
      end
    end
  endtask

  // Checks an idle window of the given length with the expected held result
  task automatic check_idle(input int cycles, input string name);
    for (int cyc = 1; cyc <= cycles; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b0;
      vecs++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== exp_result) begin
        errs++;
        $display("FAIL %s idle cyc=%0d got busy=%b done=%b result=%h want 0/0/%h",
                 name, cyc, busy, done, result, exp_result);
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    exp_result = '0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errs++;
      $display("FAIL reset got busy=%b done=%b result=%h want 0/0/0", busy, done, result);
    end
  endtask

  task automatic test_directed();
    run_op(2'b01, 32'd100,        32'd7,        32'd14,        "divu_100_7");
    run_op(2'b11, 32'd100,        32'd7,        32'd2,         "remu_100_7");
    run_op(2'b00, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, "rem_m7_2");
    run_op(2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,        "rem_7_m2");
    run_op(2'b00, 32'd5,          32'd0,        32'hFFFF_FFFF, "div_by_zero");
    run_op(2'b10, 32'd5,          32'd0,        32'd5,         "rem_by_zero");
    run_op(2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,        "rem_ovf");
    run_op(2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,        "divu_big");
    check_idle(2, "directed_tail");
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'($urandom_range(1, 20));
        1: y = 32'h0;
        2: y = 32'hFFFF_FFFF;
        3: x = 32'h8000_0000;
        4: begin x = 32'($urandom_range(0, 1000)); y = -32'($urandom_range(1, 50)); end
        default: ;
      endcase
      run_op(o, x, y, ref_result(o, x, y), "random");
    end
    check_idle(1, "random_tail");
  endtask

  // Mid-operation start is ignored, reset aborts with no done
  task automatic test_abort();
    logic eb;
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd100;
    b     = 32'd7;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 10) begin
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd55;
        b     = 32'd3;
      end
      if (cyc == 20) rst = 1'b1;
      eb = 1'b1;
      vecs++;
      if (busy !== eb || done !== 1'b0) begin
        errs++;
        $display("FAIL abort run cyc=%0d got busy=%b done=%b want 1/0", cyc, busy, done);
      end
    end
    exp_result = '0;
    check_idle(40, "abort_after_rst");
  endtask

  // Reset and start in the same cycle: start must be dropped
  task automatic test_rst_start();
    rst   = 1'b1;
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd1000;
    b     = 32'd3;
    exp_result = '0;
    check_idle(40, "rst_with_start");
  endtask

  task automatic test_back_to_back();
    run_op(2'b01, 32'd100,       32'd7,  32'd14,        "b2b_first");
    run_op(2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, "b2b_second");
    run_op(2'b00, 32'd5,         32'd0,  32'hFFFF_FFFF, "b2b_zero");
    run_op(2'b11, 32'd1234567,   32'd1000, 32'd567,     "b2b_third");
    check_idle(3, "b2b_tail");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_rst_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rv_div_unit.md
# rv_div_unit

Multi-cycle RV32M divide/remainder unit: the subtraction-side counterpart of the ripple-carry adder in the ALU datapath. It computes DIV, DIVU, REM and REMU with a restoring shift-subtract algorithm, producing one quotient bit per cycle. It sits beside the ALU and stalls the core through `busy` until `done` pulses. It follows the RISC-V rules for divide-by-zero and signed overflow.

## Interface
- `N`, 32, operand/result width

- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `A`  in  N  dividend, sampled with `start`
- `B`  in  N  divisor, sampled with `start`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse, `result` valid
- `result`  out  N  quotient or remainder, held until next `done`

## Operation
- States:
  - IDLE: `start` captures `op`, `A`, `B` → CALC.
  - CALC: N iterations, counter N-1 down to 0 → FIX when counter = 0.
  - FIX: sign correction, special cases, register `result`, pulse `done` → IDLE.
- Signed ops (DIV, REM):
  - Operands are converted to magnitudes at capture.
  - `neg_q` = A[N-1] ^ B[N-1].
  - `neg_r` = A[N-1].
- Each iteration:
  - Partial remainder is N+1 bits: `diff` = {rem[N-1:0], dvd[N-1]} − {1'b0, |B|}.
  - If `diff` ≥ 0: rem ← diff, qbit = 1.
  - Else: rem ← shifted value, qbit = 0.
  - Dividend shifts left, qbit enters at the LSB.
- FIX:
  - Quotient is negated if `neg_q`; remainder is negated if `neg_r` (signed ops only).
  - `op[1]` selects remainder, else quotient.
- Special cases, resolved in FIX and overriding the computed value:
  - B = 0: quotient = all ones; remainder = A.
  - Signed op with A = 0x80000000 and B = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- `start` while not IDLE is ignored; operands are not re-sampled.
- Unsigned ops never negate.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `result` = 0.
  - State IDLE, counter 0, all internal registers 0.
- `start` at cycle 0 gives:
  - `busy` = 1 for cycles 1..N+1.
  - `done` = 1 and `result` valid at cycle N+2.
  - Latency is N+2 (34 for N=32).
- At the `done` cycle the state is already IDLE and `busy` = 0.
  - A `start` in that cycle is accepted: back-to-back throughput is one op per N+2 cycles.
- `done` lasts exactly one cycle. `result` stays stable until the next `done`.
- `rst` mid-operation:
  - Returns to IDLE the next edge; `busy`/`done`/`result` cleared.
  - No `done` for the aborted op.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.

## Configuration
- `DIV_EARLY_OUT_EN`
  - Defined: in IDLE, if B = 0 or signed overflow is detected, the unit skips CALC and goes straight to FIX.
    - `busy` high at cycle 1 only; `done` at cycle 2.
    - Result values as in Operation.
  - Undefined: all operations take N+2 cycles. Special-case results are applied in FIX over the iterated value, giving a fixed, data-independent latency.

## Test plan
- DIVU A=100, B=7, start at cycle 0 → `busy` for cycles 1–33; `done` at cycle 34 with `result`=14. Repeat with REMU → 2.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). REM A=7, B=0xFFFFFFFE → 1.
- DIV A=5, B=0 → 0xFFFFFFFF. REM A=5, B=0 → 5.
  - Latency: 34 cycles without the macro, 2 cycles with `DIV_EARLY_OUT_EN`.
- DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM → 0. DIVU with the same operands → 0, via normal iteration.
- Start DIVU 100/7, pulse `start` with new operands at cycle 10, assert `rst` at cycle 20 → the second start is ignored; `busy`/`done`/`result` = 0 from cycle 21; no `done` ever appears.
- Back-to-back: assert `start` again in the `done` cycle (DIVU 0xFFFFFFFF/0x10) → second `done` 34 cycles later with 0x0FFFFFFF; the first `result` holds until then.
